// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types for the arbitrated adder.
// Holds FSM state encoding, width default and overflow helper.
package adder_arbiter_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic ovf_f(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: WIDTH-bit adder, 4-bit lookahead blocks.
// Ports: a, b, cin in; sum out (carry-out not exported).
module carry_look_ahead_adder #(
  parameter int WIDTH = 32
)(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NB:0]      bc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    int l;
    logic gg;
    logic pg;
    c = '0;
    bc = '0;
    bc[0] = cin;
    l = 0;
    gg = 1'b0;
    pg = 1'b0;
    for (int k = 0; k < NB; k++) begin
      l = 4 * k;
      c[l]   = bc[k];
      c[l+1] = g[l] | (p[l] & bc[k]);
      c[l+2] = g[l+1] | (p[l+1] & g[l])
             | (p[l+1] & p[l] & bc[k]);
      c[l+3] = g[l+2] | (p[l+2] & g[l+1])
             | (p[l+2] & p[l+1] & g[l])
             | (p[l+2] & p[l+1] & p[l] & bc[k]);
      gg = g[l+3] | (p[l+3] & g[l+2])
         | (p[l+3] & p[l+2] & g[l+1])
         | (p[l+3] & p[l+2] & p[l+1] & g[l]);
      pg = &p[l +: 4];
      bc[k+1] = gg | (pg & bc[k]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after ptr.
// Ports: req, ptr in; one-hot grant and grant_idx out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin shares one CLA adder among requesters.
// Ports: req_* valid/ready/operands in, rsp_* result channel, busy.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_overflow,
  output logic                     busy
);

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    op_id;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   add_sum;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  carry_look_ahead_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (add_sum)
  );

  assign sel_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign accept = (state == IDLE) && (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (1'b1)
      (state == IDLE): begin
        req_ready = grant;
        busy      = 1'b0;
      end
      (state == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= '0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_id  <= grant_idx;
        rr_ptr <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_sum      <= add_sum;
        rsp_overflow <= ovf_f(op_a[WIDTH-1], op_b[WIDTH-1],
                              add_sum[WIDTH-1]);
        rsp_id       <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scoreboard bench for adder_arbiter.
// Driver pushes expected responses; monitor pops on handshake.
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_overflow;
  logic         busy;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;

  adder_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request and expect requester g to win arbitration.
  task automatic issue(input logic [3:0] mask, input int g,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic eo,
                       input bit hold, input bit push);
    int n;
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
    req_valid = mask;
    n = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got none expected %0d", g);
    end else begin
      chk("grant_onehot", 32'(req_ready), 32'(4'b1 << g));
      if (push) q.push_back('{id: 2'(g), sum: es, ovf: eo});
      @(posedge clk);
      #1;
      prev_acc = acc_cyc;
      acc_cyc = cyc;
    end
    if (!hold) req_valid = '0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({nm, "_rsp_id"}, 32'(rsp_id), 32'h0);
    chk({nm, "_rsp_sum"}, rsp_sum, 32'h0);
    chk({nm, "_rsp_ovf"}, 32'(rsp_overflow), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d expected none",
                   rsp_id);
        end else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_sum", rsp_sum, e.sum);
          chk("rsp_ovf", 32'(rsp_overflow), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] t2_a[4] = '{32'h00000005, 32'hFFFFFFFF,
                           32'h80000000, 32'h40000000};
  logic [31:0] t2_b[4] = '{32'h00000003, 32'h00000001,
                           32'h80000000, 32'h40000000};
  logic [31:0] t2_s[4] = '{32'h00000008, 32'h00000000,
                           32'h00000000, 32'h80000000};
  logic        t2_o[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single request, latency and busy
    issue(4'b0001, 0, 32'h7FFFFFFF, 32'h00000001,
          32'h80000000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_exec_valid", 32'(rsp_valid), 32'h0);
    chk("t1_exec_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_resp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_resp_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_valid", 32'(rsp_valid), 32'h0);

    // 2: all requesting, rotation and 3-cycle throughput
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(4'b1111, i % 4, t2_a[i%4], t2_b[i%4],
            t2_s[i%4], t2_o[i%4], i < 4, 1'b1);
      if (i > 0) chk("t2_gap", 32'(acc_cyc - prev_acc), 32'd3);
    end

    // 3: requester 2 edge cases
    issue(4'b0100, 2, 32'h80000000, 32'hFFFFFFFF,
          32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
    issue(4'b0100, 2, 32'h7FFFFFFF, 32'h80000000,
          32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    issue(4'b0100, 2, 32'h00000000, 32'hFFFFFFFF,
          32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);

    // 4: response back-pressure
    issue(4'b0001, 0, 32'h1A2B3C4D, 32'h5F6E7D8C,
          32'h7999B9D9, 1'b0, 1'b0, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 32'(rsp_valid), 32'h1);
      chk("t4_stall_sum", rsp_sum, 32'h7999B9D9);
      chk("t4_stall_ovf", 32'(rsp_overflow), 32'h0);
      chk("t4_stall_id", 32'(rsp_id), 32'h0);
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;

    // 4 follow-on / 5: rotation skips idle requesters
    issue(4'b1111, 1, 32'h00000001, 32'h00000002,
          32'h00000003, 1'b0, 1'b0, 1'b1);
    issue(4'b1001, 3, 32'h12345678, 32'h11111111,
          32'h23456789, 1'b0, 1'b0, 1'b1);
    issue(4'b1001, 0, 32'hFFFFFFFE, 32'hFFFFFFFE,
          32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);

    // 6: async reset mid-operation drops it
    issue(4'b1111, 1, 32'h00000001, 32'h00000001,
          32'h00000002, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_async");
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'b1111, 0, 32'h00000010, 32'h00000020,
          32'h00000030, 1'b0, 1'b0, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
